// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// The bus is one packed vector laid out as {addr, data, ctrl}.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        PARK       = 3'b001,
        GRANT      = 3'b010,
        TURNAROUND = 3'b100
    } state_t;

    localparam int CTRL_WIDTH = 4;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority selector: picks the first requester above i_last,
// wrapping modulo NUM_MASTERS, so the previous owner ranks lowest.
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int IW          = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IW-1:0]          i_last,
    output logic [IW-1:0]          o_winner,
    output logic                   o_any_req
);

    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW:0]   w_idx;

    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (a latch).
    always_comb begin
        o_winner  = '0;
        o_any_req = |i_req;
        w_found   = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_sum = {1'b0, i_last} + (IW + 1)'(i);
            w_idx = (w_sum >= (IW + 1)'(NUM_MASTERS)) ? w_sum - (IW + 1)'(NUM_MASTERS) : w_sum;
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                o_winner = w_idx[IW-1:0];
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: parks the bus at zero when idle, inserts a
// one-cycle turnaround between owners and revokes grants that never finish.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int OW             = idx_width(NUM_MASTERS),
    localparam int CW             = $clog2(TIMEOUT_CYCLES),
    localparam int BUS_WIDTH      = ADDR_WIDTH + DATA_WIDTH + CTRL_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] done,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [NUM_MASTERS-1:0] bus_error,
    output logic [OW-1:0]          owner,
    output logic                   owner_valid,
    inout  wire  [BUS_WIDTH-1:0]   bus
);

    state_t                 r_state,     w_state_nx;
    logic [OW-1:0]          r_last,      w_last_nx;
    logic [OW-1:0]          r_owner,     w_owner_nx;
    logic [CW-1:0]          r_cnt,       w_cnt_nx;
    logic [NUM_MASTERS-1:0] r_gnt,       w_gnt_nx;
    logic [NUM_MASTERS-1:0] r_bus_error, w_bus_error_nx;

    logic [OW-1:0]          w_winner;
    logic                   w_any_req;
    logic                   w_release;
    logic                   w_timeout;

    rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .i_req     (req),
        .i_last    (r_last),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    assign w_release = done[r_owner] | ~req[r_owner];
    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nx     = r_state;
        w_last_nx      = r_last;
        w_owner_nx     = r_owner;
        w_cnt_nx       = r_cnt;
        w_gnt_nx       = r_gnt;
        w_bus_error_nx = '0;
        case (r_state)
            PARK: begin
                if (w_any_req) begin
                    w_state_nx           = GRANT;
                    w_gnt_nx             = '0;
                    w_gnt_nx[w_winner]   = 1'b1;
                    w_owner_nx           = w_winner;
                    w_last_nx            = w_winner;
                    w_cnt_nx             = '0;
                end
            end
            GRANT: begin
                // A completion in the timeout cycle is a normal release, not an error.
                if (w_release || w_timeout) begin
                    w_state_nx = TURNAROUND;
                    w_gnt_nx   = '0;
                    w_owner_nx = '0;
                    w_cnt_nx   = '0;
                    if (!w_release) w_bus_error_nx[r_owner] = 1'b1;
                end else begin
                    // The exit at TIMEOUT_CYCLES-1 caps the count, so it never wraps.
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            TURNAROUND: begin
                w_state_nx = PARK;
            end
            default: begin
                w_state_nx = PARK;
                w_gnt_nx   = '0;
                w_owner_nx = '0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= PARK;
            r_last      <= OW'(NUM_MASTERS - 1);
            r_owner     <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_bus_error <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_last      <= w_last_nx;
            r_owner     <= w_owner_nx;
            r_cnt       <= w_cnt_nx;
            r_gnt       <= w_gnt_nx;
            r_bus_error <= w_bus_error_nx;
        end
    end

    assign gnt         = r_gnt;
    assign bus_error   = r_bus_error;
    assign owner       = r_owner;
    assign owner_valid = (r_state == GRANT);

    // Parked bus is held at valid zero levels; any owner drives it otherwise.
    assign bus = (r_state == PARK) ? {BUS_WIDTH{1'b0}} : {BUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random stimulus for bus_arbiter, checked against a
// cycle-count reference model of the arbitration rules.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int BW = AW + DW + CTRL_WIDTH;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic [N-1:0]  bus_error;
    logic [1:0]    owner;
    logic          owner_valid;
    wire  [BW-1:0] bus;
    logic [BW-1:0] m_val;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: who owns the bus, for how long, and whether the
    // current cycle is the mandatory quiet cycle after a release.
    int           m_owner;
    int           m_held;
    int           m_last;
    bit           m_cool;
    logic [N-1:0] m_err;

    bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .bus_error   (bus_error),
        .owner       (owner),
        .owner_valid (owner_valid),
        .bus         (bus)
    );

    // The granted master drives the bus while it holds a grant.
    assign bus = (|gnt) ? m_val : {BW{1'bz}};

    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (!n_rst) $onehot0(gnt))
        else $error("FAIL onehot_property gnt=%b required one-hot or zero", gnt);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
        m_cool  = 1'b0;
        m_err   = '0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        bit rel;
        bit tmo;
        int c;
        if (m_owner >= 0) begin
            rel = d[m_owner] || !r[m_owner];
            tmo = (m_held == TO - 1);
            if (rel || tmo) begin
                m_err   = rel ? '0 : (N'(1) << m_owner);
                m_owner = -1;
                m_cool  = 1'b1;
                m_held  = 0;
            end else begin
                m_err  = '0;
                m_held = m_held + 1;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
            m_err  = '0;
        end else begin
            m_err = '0;
            if (r != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner;
                m_held = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("gnt", gnt, eg);
        check("owner_valid", owner_valid, m_owner >= 0);
        check("owner", owner, (m_owner >= 0) ? m_owner : 0);
        check("bus_error", bus_error, m_err);
        check("gnt_onehot0", $onehot0(gnt), 1'b1);
        if (m_owner >= 0)
            check("bus_master_drive", bus, m_val);
        else if (!m_cool)
            check("bus_park", bus, '0);
    endtask

    // Apply inputs for one clock, advance the model, check after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        req  = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        m_val = {$urandom, $urandom, $urandom};
    endtask

    initial begin
        int           order[$];
        int           gaps[$];
        int           low;
        int           hold;
        int           hi;
        logic [N-1:0] prev;
        logic [N-1:0] d;
        logic [N-1:0] seen_err;
        logic [N-1:0] r;
        int           exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};
        n_rst = 1'b0;
        req   = '0;
        done  = '0;
        m_val = {$urandom, $urandom, $urandom};
        model_reset();

        // Reset state
        #3;
        check("reset_gnt", gnt, '0);
        check("reset_owner_valid", owner_valid, 1'b0);
        check("reset_bus", bus, '0);
        @(negedge clk);
        n_rst = 1'b1;
        check_outputs();

        // Contention: all request, each owner finishes 3 cycles after its grant
        low  = 0;
        hold = 0;
        prev = gnt;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            d = (gnt != '0 && hold == 2) ? gnt : '0;
            step(4'b1111, d);
            if (gnt != '0 && prev == '0) begin
                order.push_back(int'(owner));
                gaps.push_back(low);
                low  = 0;
                hold = 0;
            end else if (gnt != '0) begin
                hold++;
            end else begin
                low++;
            end
            prev = gnt;
        end
        check("contention_grants", order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check($sformatf("contention_order%0d", i), order[i], exp_order[i]);
            if (i > 0 && i < gaps.size()) check($sformatf("contention_gap%0d", i), gaps[i], 2);
        end
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Round-robin wrap: after owner 3, 1 beats 3; then 3 follows 1
        step(4'b1000, 4'b0000);
        check("wrap_own3", gnt, 4'b1000);
        step(4'b1000, 4'b1000);
        step(4'b0000, 4'b0000);
        step(4'b1010, 4'b0000);
        check("wrap_grant1", gnt, 4'b0010);
        step(4'b1010, 4'b0010);
        step(4'b1010, 4'b0000);
        step(4'b1010, 4'b0000);
        check("wrap_grant3", gnt, 4'b1000);
        step(4'b0000, 4'b0000);

        // Timeout: master 1 never finishes
        hi       = 0;
        seen_err = '0;
        for (int c = 0; c < 30 && seen_err == '0; c++) begin
            step(4'b0010, 4'b0000);
            if (gnt[1]) hi++;
            seen_err = bus_error;
        end
        check("timeout_high_cycles", hi, TO);
        check("timeout_bus_error", seen_err, 4'b0010);
        step(4'b0010, 4'b0000);
        check("timeout_error_one_cycle", bus_error, 4'b0000);
        check("timeout_gap_low", gnt, 4'b0000);
        step(4'b0010, 4'b0000);
        check("timeout_regrant", gnt, 4'b0010);

        // Done collides with the timeout cycle: clean release
        for (int c = 0; c < TO - 1; c++) step(4'b0010, 4'b0000);
        step(4'b0010, 4'b0010);
        check("collision_no_error", bus_error, 4'b0000);
        check("collision_release", gnt, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);

        // Foreign done ignored; owner withdrawal releases
        step(4'b0001, 4'b0000);
        check("ignore_grant0", gnt, 4'b0001);
        step(4'b0001, 4'b0100);
        check("ignore_foreign_done", gnt, 4'b0001);
        step(4'b0000, 4'b0000);
        check("withdraw_turnaround", gnt, 4'b0000);
        step(4'b0000, 4'b0000);
        check("withdraw_park_bus", bus, '0);

        // Asynchronous reset during a grant to master 2
        step(4'b0100, 4'b0000);
        step(4'b0100, 4'b0000);
        check("pre_reset_owner2", gnt, 4'b0100);
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check("midreset_gnt", gnt, '0);
        check("midreset_owner_valid", owner_valid, 1'b0);
        check("midreset_bus_error", bus_error, '0);
        check("midreset_bus", bus, '0);
        @(negedge clk);
        req   = 4'b0001;
        n_rst = 1'b1;
        check_outputs();
        step(4'b0001, 4'b0000);
        check("post_reset_grant0", gnt, 4'b0001);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 3) == 0) ? N'($urandom) : req;
            d = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            step(r, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
